// File: rtl/fir_delay_ring_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_delay_ring_if
//  Brief    : Bundle of sample-write, sweep-request and tap read-out signals
//             for the multi-channel FIR delay ring.
//  Revision : 1.0  initial release
// ============================================================================
interface fir_delay_ring_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int CH     = 1
);
    localparam int c_TAP_W = $clog2(DEPTH);
    localparam int c_CH_W  = (CH > 1) ? $clog2(CH) : 1;

    // History control
    logic                flush;

    // Sample write side
    logic                in_valid;
    logic                in_ready;
    logic [c_CH_W-1:0]   in_ch;
    logic [DATA_W-1:0]   in_data;
    logic                wr_done;

    // Sweep request side
    logic                sweep_start;
    logic [c_CH_W-1:0]   sweep_ch;
    logic                sweep_busy;

    // Tap read-out stream
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [c_TAP_W-1:0]  out_tap;
    logic                out_last;

    // Producer/consumer side that drives requests and observes results
    modport master (
        output flush,
        output in_valid, in_ch, in_data,
        output sweep_start, sweep_ch,
        input  in_ready, wr_done,
        input  sweep_busy,
        input  out_valid, out_data, out_tap, out_last
    );

    // Delay ring side
    modport slave (
        input  flush,
        input  in_valid, in_ch, in_data,
        input  sweep_start, sweep_ch,
        output in_ready, wr_done,
        output sweep_busy,
        output out_valid, out_data, out_tap, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fir_delay_ring.sv
`default_nettype none
// ============================================================================
//  Module   : fir_delay_ring
//  Brief    : Per-channel circular sample history for FIR filters. Samples
//             are written into a ring (no shifting); a sweep streams all
//             DEPTH taps of one channel, newest first, with unfilled taps
//             reading as zero.
//  Revision : 1.0  initial release
// ============================================================================
module fir_delay_ring #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int CH     = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fir_delay_ring_if.slave bus
);
    // ------------------------------------------------------------------------
    // Derived sizes. Channel-indexed storage is rounded up to a power of two
    // so every channel code (even an illegal one) indexes a real entry; the
    // illegal codes are simply never written.
    // ------------------------------------------------------------------------
    localparam int c_TAP_W  = $clog2(DEPTH);
    localparam int c_CH_W   = (CH > 1) ? $clog2(CH) : 1;
    localparam int c_CH_N   = 1 << c_CH_W;
    localparam int c_ADDR_W = c_CH_W + c_TAP_W;
    localparam int c_MEM_N  = 1 << c_ADDR_W;

    localparam logic [c_TAP_W-1:0] c_LAST_TAP = c_TAP_W'(DEPTH - 1);
    localparam logic [c_TAP_W:0]   c_FULL     = (c_TAP_W + 1)'(DEPTH);
    localparam logic [c_CH_W:0]    c_CH_LIM   = (c_CH_W + 1)'(CH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t               r_state_q;
    state_t               w_state_d;
    logic [c_TAP_W-1:0]   r_tap_q;        // tap being issued this cycle
    logic [c_TAP_W-1:0]   w_tap_d;
    logic [c_CH_W-1:0]    r_sch_q;        // channel captured at sweep start
    logic [c_CH_W-1:0]    w_sch_d;
    logic                 w_issue;        // a tap read is launched this cycle

    logic [c_TAP_W-1:0]   r_wp_q [c_CH_N];   // next entry to write
    logic [c_TAP_W:0]     r_fc_q [c_CH_N];   // valid history length, 0..DEPTH

    logic [DATA_W-1:0]    r_mem  [c_MEM_N];  // {channel, ring index}

    logic                 r_wr_done_q;
    logic                 r_out_valid_q;
    logic                 r_out_live_q;   // tap lies within the filled history
    logic                 r_out_last_q;
    logic [c_TAP_W-1:0]   r_out_tap_q;
    logic [DATA_W-1:0]    r_rd_data_q;

    // ------------------------------------------------------------------------
    // Handshake qualification
    // ------------------------------------------------------------------------
    logic                 w_busy;
    logic                 w_in_ready;
    logic                 w_in_ch_ok;
    logic                 w_sw_ch_ok;
    logic                 w_wr_acc;
    logic                 w_sw_acc;
    logic [c_ADDR_W-1:0]  w_wr_addr;
    logic [c_TAP_W-1:0]   w_rd_idx;
    logic [c_ADDR_W-1:0]  w_rd_addr;
    logic                 w_rd_live;

    // Busy covers the issue phase plus the cycle the final tap is presented,
    // since the read pipeline lags the issuing state by one cycle.
    assign w_busy     = (r_state_q == S_SWEEP) | r_out_valid_q;
    assign w_in_ready = ~w_busy & ~bus.flush;

    assign w_in_ch_ok = ({1'b0, bus.in_ch}    < c_CH_LIM);
    assign w_sw_ch_ok = ({1'b0, bus.sweep_ch} < c_CH_LIM);

    assign w_wr_acc   = bus.in_valid    & w_in_ready & w_in_ch_ok;
    assign w_sw_acc   = bus.sweep_start & ~w_busy & ~bus.flush & w_sw_ch_ok;

    assign w_wr_addr  = {bus.in_ch, r_wp_q[bus.in_ch]};

    // Tap k lives k+1 entries behind the write pointer (tap 0 = newest).
    assign w_rd_idx   = r_wp_q[r_sch_q] - r_tap_q - c_TAP_W'(1);
    assign w_rd_addr  = {r_sch_q, w_rd_idx};
    assign w_rd_live  = ({1'b0, r_tap_q} < r_fc_q[r_sch_q]);

    // ------------------------------------------------------------------------
    // Sweep FSM: state, tap counter and captured channel registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_tap_q   <= '0;
            r_sch_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_tap_q   <= w_tap_d;
            r_sch_q   <= w_sch_d;
        end
    end

    // Sweep FSM next state: flush aborts; IDLE waits for a legal request;
    // SWEEP issues one tap per cycle and returns after the last one.
    always_comb begin
        w_state_d = r_state_q;
        w_tap_d   = r_tap_q;
        w_sch_d   = r_sch_q;
        w_issue   = 1'b0;

        if (bus.flush) begin
            w_state_d = S_IDLE;
            w_tap_d   = '0;
        end else begin
            case (r_state_q)
                S_IDLE: begin
                    if (w_sw_acc) begin
                        w_state_d = S_SWEEP;
                        w_tap_d   = '0;
                        w_sch_d   = bus.sweep_ch;
                    end
                end
                S_SWEEP: begin
                    w_issue = 1'b1;
                    w_tap_d = r_tap_q + c_TAP_W'(1);
                    if (r_tap_q == c_LAST_TAP) begin
                        w_state_d = S_IDLE;
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase
        end
    end

    // Per-channel write pointer and saturating fill count
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int i = 0; i < c_CH_N; i++) begin
                r_wp_q[i] <= '0;
                r_fc_q[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_wp_q[bus.in_ch] <= r_wp_q[bus.in_ch] + c_TAP_W'(1);
            if (r_fc_q[bus.in_ch] != c_FULL) begin
                r_fc_q[bus.in_ch] <= r_fc_q[bus.in_ch] + (c_TAP_W + 1)'(1);
            end
        end
    end

    // Sample storage: write port for accepted samples, registered tap read.
    // Contents are never cleared; the fill count masks stale entries.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_addr] <= bus.in_data;
        end
        r_rd_data_q <= r_mem[w_rd_addr];
    end

    // Output stage aligned with the registered read: tap index, last flag,
    // live mask and the write-completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_done_q   <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_out_live_q  <= 1'b0;
            r_out_last_q  <= 1'b0;
            r_out_tap_q   <= '0;
        end else begin
            r_wr_done_q   <= w_wr_acc;
            r_out_valid_q <= w_issue;
            r_out_live_q  <= w_issue & w_rd_live;
            r_out_last_q  <= w_issue & (r_tap_q == c_LAST_TAP);
            r_out_tap_q   <= w_issue ? r_tap_q : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Data is zero both for idle cycles and for taps beyond the
    // filled history, so the raw RAM word never leaks out.
    // ------------------------------------------------------------------------
    assign bus.in_ready   = w_in_ready;
    assign bus.wr_done    = r_wr_done_q;
    assign bus.sweep_busy = w_busy;
    assign bus.out_valid  = r_out_valid_q;
    assign bus.out_data   = r_out_live_q ? r_rd_data_q : '0;
    assign bus.out_tap    = r_out_tap_q;
    assign bus.out_last   = r_out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_delay_ring.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_delay_ring
//  Brief    : Self-checking bench for fir_delay_ring (DEPTH=4, CH=3):
//             table-driven writes, directed sweep sequences and a random
//             phase, all shadowed by a queue-based history model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_delay_ring;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int CH     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_delay_ring_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH(CH)) bus ();

    fir_delay_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CH(CH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected read-out for one future cycle
    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic [1:0]  t;
        logic        l;
    } exp_t;

    // Table vector: one write attempt plus expected handshake results
    typedef struct {
        logic        iv;
        logic [1:0]  ch;
        logic [15:0] d;
        logic        exp_ready;
        logic        exp_wrd;    // wr_done in the following cycle
    } vec_t;

    // Reference model: newest-first history per channel, schedule of
    // expected outputs for upcoming cycles, busy flag for the current cycle.
    logic [15:0] hist [CH][$];
    exp_t        sched[$];
    logic        m_busy;
    logic        m_wrd;

    int n_checks = 0;
    int n_err    = 0;

    // Observations of the most recent cycle
    logic        o_ready, o_valid, o_last, o_busy, o_wrd;
    logic [15:0] o_data;
    logic [1:0]  o_tap;
    logic [15:0] got [DEPTH];

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk4(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        chk({nm, "_t0"}, {16'h0, got[0]}, {16'h0, e0});
        chk({nm, "_t1"}, {16'h0, got[1]}, {16'h0, e1});
        chk({nm, "_t2"}, {16'h0, got[2]}, {16'h0, e2});
        chk({nm, "_t3"}, {16'h0, got[3]}, {16'h0, e3});
    endtask

    // One clock cycle: drive inputs, check in_ready, advance the model,
    // clock the DUT, then check every registered output against the model.
    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [1:0] ich, input logic [15:0] idat,
                         input logic ss, input logic [1:0] sch);
        exp_t e;
        rst             = r;
        bus.flush       = fl;
        bus.in_valid    = iv;
        bus.in_ch       = ich;
        bus.in_data     = idat;
        bus.sweep_start = ss;
        bus.sweep_ch    = sch;
        #1;
        o_ready = bus.in_ready;
        chk("in_ready", {31'h0, o_ready}, {31'h0, (!m_busy && !fl)});

        m_wrd = 1'b0;
        if (r || fl) begin
            for (int i = 0; i < CH; i++) hist[i].delete();
            sched.delete();
        end else begin
            if (iv && !m_busy && (ich < CH)) begin
                hist[ich].push_front(idat);
                if (hist[ich].size() > DEPTH) void'(hist[ich].pop_back());
                m_wrd = 1'b1;
            end
            if (ss && !m_busy && (sch < CH)) begin
                sched.delete();
                sched.push_back('0);
                for (int k = 0; k < DEPTH; k++) begin
                    e.v = 1'b1;
                    e.d = (k < hist[sch].size()) ? hist[sch][k] : 16'h0;
                    e.t = 2'(k);
                    e.l = (k == DEPTH - 1);
                    sched.push_back(e);
                end
            end
        end

        @(posedge clk);
        #1;
        if (sched.size() > 0) begin
            e      = sched.pop_front();
            m_busy = 1'b1;
        end else begin
            e      = '0;
            m_busy = 1'b0;
        end

        o_valid = bus.out_valid;
        o_data  = bus.out_data;
        o_tap   = bus.out_tap;
        o_last  = bus.out_last;
        o_busy  = bus.sweep_busy;
        o_wrd   = bus.wr_done;
        chk("out_valid",  {31'h0, o_valid}, {31'h0, e.v});
        chk("out_data",   {16'h0, o_data},  {16'h0, e.d});
        chk("out_tap",    {30'h0, o_tap},   {30'h0, e.t});
        chk("out_last",   {31'h0, o_last},  {31'h0, e.l});
        chk("sweep_busy", {31'h0, o_busy},  {31'h0, m_busy});
        chk("wr_done",    {31'h0, o_wrd},   {31'h0, m_wrd});
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    endtask

    // Full sweep of one channel, optionally with a same-cycle write to it;
    // taps are left in got[] for the caller to compare with constants.
    task automatic sweep_collect(input logic [1:0] sch, input logic iv, input logic [15:0] d);
        cycle(1'b0, 1'b0, iv, sch, d, 1'b1, sch);
        chk("sw_first_gap", {31'h0, o_valid}, 32'h0);
        chk("sw_busy_c1",   {31'h0, o_busy},  32'h1);
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            got[k] = o_data;
            chk("sw_valid", {31'h0, o_valid}, 32'h1);
            chk("sw_tap",   {30'h0, o_tap},   32'(k));
            chk("sw_last",  {31'h0, o_last},  {31'h0, (k == DEPTH - 1)});
        end
        idle();
        chk("sw_busy_end", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        logic acc;

        // --- reset ---------------------------------------------------------
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_ch       = '0;
        bus.in_data     = '0;
        bus.sweep_start = 1'b0;
        bus.sweep_ch    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",  {31'h0, bus.out_valid},  32'h0);
        chk("rst_out_data",   {16'h0, bus.out_data},   32'h0);
        chk("rst_out_tap",    {30'h0, bus.out_tap},    32'h0);
        chk("rst_out_last",   {31'h0, bus.out_last},   32'h0);
        chk("rst_sweep_busy", {31'h0, bus.sweep_busy}, 32'h0);
        chk("rst_wr_done",    {31'h0, bus.wr_done},    32'h0);
        m_busy = 1'b0;
        m_wrd  = 1'b0;

        // --- table-driven writes -------------------------------------------
        tbl[0] = '{1'b1, 2'd0, 16'h0011, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 2'd0, 16'h0022, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 2'd0, 16'h0033, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 2'd2, 16'h000A, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 2'd1, 16'h000B, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 2'd3, 16'h00EE, 1'b1, 1'b0};   // illegal channel
        tbl[6] = '{1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, tbl[i].iv, tbl[i].ch, tbl[i].d, 1'b0, 2'd0);
            chk("tbl_ready",   {31'h0, o_ready}, {31'h0, tbl[i].exp_ready});
            chk("tbl_wr_done", {31'h0, o_wrd},   {31'h0, tbl[i].exp_wrd});
        end

        // --- partial history, newest first, unfilled taps zero -------------
        sweep_collect(2'd0, 1'b0, 16'h0);
        chk4("partial", 16'h0033, 16'h0022, 16'h0011, 16'h0000);
        sweep_collect(2'd2, 1'b0, 16'h0);
        chk4("ch_indep", 16'h000A, 16'h0000, 16'h0000, 16'h0000);

        // --- illegal sweep channel is a no-op --------------------------------
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
        chk("bad_sweep_busy", {31'h0, o_busy}, 32'h0);
        idle();
        chk("bad_sweep_valid", {31'h0, o_valid}, 32'h0);

        // --- wrap-around with saturated fill ---------------------------------
        for (int i = 1; i <= 6; i++) cycle(1'b0, 1'b0, 1'b1, 2'd1, 16'(i), 1'b0, 2'd0);
        sweep_collect(2'd1, 1'b0, 16'h0);
        chk4("wrap", 16'h0006, 16'h0005, 16'h0004, 16'h0003);

        // --- in_valid held across a sweep ------------------------------------
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
        lows = 0;
        acc  = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            cycle(1'b0, 1'b0, 1'b1, 2'd2, 16'h0077, 1'b0, 2'd0);
            if (o_ready) acc = 1'b1;
            else lows++;
        end
        chk("hold_ready_low", 32'(lows), 32'(DEPTH + 1));
        chk("hold_wr_done", {31'h0, o_wrd}, 32'h1);
        idle();
        chk("hold_no_dup", {31'h0, o_wrd}, 32'h0);
        sweep_collect(2'd2, 1'b0, 16'h0);
        chk4("hold", 16'h0077, 16'h000A, 16'h0000, 16'h0000);

        // --- write and sweep in the same cycle -------------------------------
        sweep_collect(2'd0, 1'b1, 16'h0055);
        chk4("same_cycle", 16'h0055, 16'h0033, 16'h0022, 16'h0011);

        // --- flush at the third output of a sweep ----------------------------
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
        idle();
        idle();
        idle();
        chk("flush_pre_tap", {30'h0, o_tap}, 32'h2);
        cycle(1'b0, 1'b1, 1'b1, 2'd0, 16'h0099, 1'b0, 2'd0);
        chk("flush_ready", {31'h0, o_ready}, 32'h0);
        chk("flush_valid", {31'h0, o_valid}, 32'h0);
        chk("flush_busy",  {31'h0, o_busy},  32'h0);
        chk("flush_wrd",   {31'h0, o_wrd},   32'h0);
        sweep_collect(2'd1, 1'b0, 16'h0);
        chk4("post_flush1", 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        sweep_collect(2'd0, 1'b0, 16'h0);
        chk4("post_flush0", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // --- reset in the middle of a sweep ----------------------------------
        cycle(1'b0, 1'b0, 1'b1, 2'd0, 16'h0042, 1'b0, 2'd0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        idle();
        idle();
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
        chk("rst_mid_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_mid_busy",  {31'h0, o_busy},  32'h0);
        idle();
        chk("rst_mid_ready", {31'h0, o_ready}, 32'h1);
        sweep_collect(2'd0, 1'b0, 16'h0);
        chk4("post_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // --- random traffic against the model -------------------------------
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 63) == 0,
                  1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  16'($urandom),
                  $urandom_range(0, 7) == 0,
                  2'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_delay_ring.md
FIR_DELAY_RING -- requirements
Module: fir_delay_ring

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, taps per channel; power of 2, at least 2.
REQ-003 SHALL have parameter CH, default 1, independent channel count, at least 1; TAP_W = clog2(DEPTH), CH_W = max(1, clog2(CH)).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all channel history.
REQ-007 SHALL have port in_valid  input  1  sample offered.
REQ-008 SHALL have port in_ready  output  1  sample can be accepted.
REQ-009 SHALL have port in_ch  input  CH_W  channel of offered sample.
REQ-010 SHALL have port in_data  input  DATA_W  offered sample.
REQ-011 SHALL have port wr_done  output  1  one-cycle pulse after each accepted sample.
REQ-012 SHALL have port sweep_start  input  1  request read-out of all taps of one channel.
REQ-013 SHALL have port sweep_ch  input  CH_W  channel to sweep.
REQ-014 SHALL have port sweep_busy  output  1  sweep in progress.
REQ-015 SHALL have port out_valid  output  1  out_data/out_tap valid this cycle.
REQ-016 SHALL have port out_data  output  DATA_W  tap sample.
REQ-017 SHALL have port out_tap  output  TAP_W  tap index of out_data.
REQ-018 SHALL have port out_last  output  1  marks tap DEPTH-1.

Function
REQ-019 SHALL store samples per channel in a circular buffer (write pointer wp[ch] plus fill count fc[ch], 0..DEPTH saturating); no data shifting.
REQ-020 SHALL accept a sample when in_valid and in_ready are both high: write to entry wp[in_ch], advance wp[in_ch] modulo DEPTH, increment fc[in_ch] saturating at DEPTH.
REQ-021 SHALL assert wr_done for exactly the one cycle following each accepted sample; otherwise 0.
REQ-022 SHALL drive in_ready = not sweep_busy and not flush.
REQ-023 SHALL define tap k of a channel as the sample accepted k acceptances ago (tap 0 = newest), stored at entry (wp-1-k) mod DEPTH.
REQ-024 SHALL return 0 for any tap k >= fc of that channel (never-written or flushed history).
REQ-025 SHALL implement FSM IDLE/SWEEP; IDLE -> SWEEP when sweep_start is high in IDLE (sweep_ch captured); SWEEP -> IDLE after issuing tap DEPTH-1.
REQ-026 SHALL ignore sweep_start while sweep_busy is high.
REQ-027 SHALL, for sweep_start accepted at cycle c, assert out_valid on cycles c+2 .. c+DEPTH+1 with out_tap = 0,1,...,DEPTH-1 consecutively, no gaps, no backpressure.
REQ-028 SHALL assert out_last only together with out_tap = DEPTH-1.
REQ-029 SHALL hold sweep_busy high from cycle c+1 through c+DEPTH+1 inclusive; a new sweep_start is accepted at c+DEPTH+2 at earliest.
REQ-030 SHALL, when a sample write and sweep_start occur in the same IDLE cycle, include the new sample as tap 0 of that sweep.
REQ-031 SHALL drive out_data, out_tap, out_last to 0 whenever out_valid is 0.
REQ-032 SHALL keep channels independent: writes to one channel never alter taps of another.
REQ-033 SHALL treat out-of-range in_ch or sweep_ch (>= CH) as a no-op: no write, no sweep, no wr_done.
REQ-034 SHALL, on flush, clear all wp and fc, abort any sweep, return to IDLE; out_valid and sweep_busy are 0 from the next cycle; the sample offered in the flush cycle is not accepted.
REQ-035 SHALL prioritise rst over flush over write/sweep.

Reset
REQ-036 SHALL, on rst high at a clock edge, set FSM to IDLE, all wp and fc to 0, wr_done, sweep_busy, out_valid, out_data, out_tap, out_last to 0.
REQ-037 SHALL make in_ready high in the first cycle after rst deasserts; reset mid-sweep terminates output from the next cycle.
REQ-038 SHALL not require storage array contents to be reset; REQ-024 masks stale data.

Verification
REQ-039 SHALL check: CH=1, DEPTH=4, write 0x11,0x22,0x33, sweep -> out_data 0x33,0x22,0x11,0x0000, out_last on fourth.
REQ-040 SHALL check: DEPTH=4, write 0x1..0x6, sweep -> 0x6,0x5,0x4,0x3 (wrap-around, fc saturated).
REQ-041 SHALL check: CH=2, write 0xA to ch0, 0xB to ch1, sweep ch0 -> tap0=0xA, taps1..3=0; wr_done pulses twice.
REQ-042 SHALL check: in_valid held during sweep -> in_ready 0 for DEPTH+1 cycles, no sample lost or duplicated after release.
REQ-043 SHALL check: write 0x55 and sweep_start in same cycle -> tap0 = 0x55, first out_valid two cycles later.
REQ-044 SHALL check: flush at third output of a sweep -> out_valid 0 next cycle; subsequent sweep returns all zeros.
